// File: rtl/sysarr_tile_sequencer_if.sv
// -----------------------------------------------------------------------------
// sysarr_tile_sequencer_if
// Row-level bus between the scratchpad/DMA row sources, the tile sequencer
// and the systolic array memory-side port.
//   Source side : w_valid/w_ready/w_data (weight rows),
//                 in_valid/in_ready/in_data/ps_data (input + partial rows)
//   Array side  : weight_en, input_en, partial_en, row_in_en, row_ps_en,
//                 array_in, array_in_partials (sequencer -> array)
//                 drained, out_en, row_out (array -> sequencer)
// Modports: master = sequencer, slave = surrounding sources/array.
// -----------------------------------------------------------------------------
interface sysarr_tile_sequencer_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic            w_valid;
  logic            w_ready;
  logic [N*DW-1:0] w_data;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*DW-1:0] ps_data;
  logic            weight_en;
  logic            input_en;
  logic            partial_en;
  logic [RW-1:0]   row_in_en;
  logic [RW-1:0]   row_ps_en;
  logic [N*DW-1:0] array_in;
  logic [N*DW-1:0] array_in_partials;
  logic            drained;
  logic            out_en;
  logic [RW-1:0]   row_out;

  modport master (
    input  w_valid, w_data, in_valid, in_data, ps_data, drained, out_en, row_out,
    output w_ready, in_ready, weight_en, input_en, partial_en,
           row_in_en, row_ps_en, array_in, array_in_partials
  );

  modport slave (
    output w_valid, w_data, in_valid, in_data, ps_data, drained, out_en, row_out,
    input  w_ready, in_ready, weight_en, input_en, partial_en,
           row_in_en, row_ps_en, array_in, array_in_partials
  );
endinterface

// File: rtl/sysarr_tile_sequencer.sv
// -----------------------------------------------------------------------------
// sysarr_tile_sequencer
// Feeds the systolic array memory-side port: loads N weight rows (N-1 down to
// 0), inserts one mandatory bubble, streams N input/partial rows (0 to N-1)
// with a programmable idle gap after each row, waits for the array to drain,
// and repeats for num_tiles tiles. Output rows returned by the array are
// checked for in-order arrival.
// Ports:
//   clk, nRST            clock, asynchronous active-low reset
//   start, abort         start pulse (IDLE only), abort to IDLE (any state)
//   reload_each, gap,    configuration latched on an accepted start
//   num_tiles
//   bus (master)         source handshakes and array-side row bus
//   busy, done           not-idle flag, one-cycle completion pulse
//   tile_idx             number of completed tiles in the current run
//   err_row_order        sticky out-of-order output row flag
// Optional build macro SYSARR_SEQ_PERF_EN adds perf_stall (LOAD_W/STREAM
// cycles with valid low) and perf_cycles (busy cycles), cleared on start.
// -----------------------------------------------------------------------------
module sysarr_tile_sequencer #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int GAP_W  = 3,
  parameter int TILE_W = 8
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    reload_each,
  input  logic [GAP_W-1:0]        gap,
  input  logic [TILE_W-1:0]       num_tiles,
  sysarr_tile_sequencer_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic [TILE_W-1:0]       tile_idx,
  output logic                    err_row_order
`ifdef SYSARR_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_stall,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_BUBBLE, S_STREAM, S_GAP, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              reload_q, reload_d;
  logic [GAP_W-1:0]  gap_cfg_q, gap_cfg_d;
  logic [TILE_W-1:0] ntiles_q, ntiles_d;
  logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
  logic              err_q, err_d;
  logic [RW-1:0]     row_q, row_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [RW-1:0]     exp_row_q, exp_row_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              weight_en_q, weight_en_d;
  logic              input_en_q, input_en_d;
  logic              partial_en_q, partial_en_d;
  logic [RW-1:0]     row_in_q, row_in_d;
  logic [RW-1:0]     row_ps_q, row_ps_d;
  logic [N*DW-1:0]   arr_in_q, arr_in_d;
  logic [N*DW-1:0]   arr_ps_q, arr_ps_d;
  logic [TILE_W:0]   tile_next_s;
`ifdef SYSARR_SEQ_PERF_EN
  logic [31:0]       perf_stall_q, perf_stall_d;
  logic [31:0]       perf_cycles_q, perf_cycles_d;
`endif

  // Ready depends on state only so sources never see a valid->ready loop.
  assign bus.w_ready           = (state_q == S_LOAD_W);
  assign bus.in_ready          = (state_q == S_STREAM);
  assign bus.weight_en         = weight_en_q;
  assign bus.input_en          = input_en_q;
  assign bus.partial_en        = partial_en_q;
  assign bus.row_in_en         = row_in_q;
  assign bus.row_ps_en         = row_ps_q;
  assign bus.array_in          = arr_in_q;
  assign bus.array_in_partials = arr_ps_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign tile_idx              = tile_idx_q;
  assign err_row_order         = err_q;
`ifdef SYSARR_SEQ_PERF_EN
  assign perf_stall            = perf_stall_q;
  assign perf_cycles           = perf_cycles_q;
`endif

  // Next-state, row issue, drain and output-order logic.
  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    gap_cfg_d    = gap_cfg_q;
    ntiles_d     = ntiles_q;
    tile_idx_d   = tile_idx_q;
    err_d        = err_q;
    row_d        = row_q;
    gap_cnt_d    = gap_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    exp_row_d    = exp_row_q;
    done_d       = 1'b0;
    weight_en_d  = 1'b0;
    input_en_d   = 1'b0;
    partial_en_d = 1'b0;
    row_in_d     = '0;
    row_ps_d     = '0;
    arr_in_d     = '0;
    arr_ps_d     = '0;
    tile_next_s  = {1'b0, tile_idx_q} + {{TILE_W{1'b0}}, 1'b1};
`ifdef SYSARR_SEQ_PERF_EN
    perf_stall_d  = perf_stall_q + {31'd0,
                    ((state_q == S_LOAD_W) && !bus.w_valid) ||
                    ((state_q == S_STREAM) && !bus.in_valid)};
    perf_cycles_d = perf_cycles_q + {31'd0, (state_q != S_IDLE)};
`endif

    // Expected-row counter advances on every output row, even a wrong one,
    // so a single swap flags once without desynchronising the rest.
    if (bus.out_en) begin
      err_d     = err_q | (bus.row_out != exp_row_q);
      exp_row_d = (exp_row_q == ROW_LAST) ? '0 : exp_row_q + RW'(1);
    end else begin
      exp_row_d = exp_row_q;
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            reload_d    = reload_each;
            gap_cfg_d   = gap;
            ntiles_d    = num_tiles;
            tile_idx_d  = '0;
            err_d       = 1'b0;
            exp_row_d   = '0;
            row_d       = ROW_LAST;
            drain_cnt_d = 2'd0;
            done_d      = (num_tiles == '0);
            state_d     = (num_tiles == '0) ? S_DONE : S_LOAD_W;
`ifdef SYSARR_SEQ_PERF_EN
            perf_stall_d  = 32'd0;
            perf_cycles_d = 32'd0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD_W: begin
          if (bus.w_valid) begin
            weight_en_d = 1'b1;
            row_in_d    = row_q;
            arr_in_d    = bus.w_data;
            if (row_q == '0) begin
              state_d = S_BUBBLE;
            end else begin
              row_d = row_q - RW'(1);
            end
          end else begin
            state_d = S_LOAD_W;
          end
        end
        S_BUBBLE: begin
          row_d   = '0;
          state_d = S_STREAM;
        end
        S_STREAM: begin
          if (bus.in_valid) begin
            input_en_d   = 1'b1;
            partial_en_d = 1'b1;
            row_in_d     = row_q;
            row_ps_d     = row_q;
            arr_in_d     = bus.in_data;
            arr_ps_d     = bus.ps_data;
            if (row_q == ROW_LAST) begin
              drain_cnt_d = 2'd0;
              state_d     = S_DRAIN;
            end else begin
              row_d     = row_q + RW'(1);
              gap_cnt_d = gap_cfg_q;
              state_d   = (gap_cfg_q != '0) ? S_GAP : S_STREAM;
            end
          end else begin
            state_d = S_STREAM;
          end
        end
        S_GAP: begin
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_d = S_STREAM;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        S_DRAIN: begin
          // The first two drain cycles ignore drained, which may still be
          // high from before the last rows reached the array.
          if (drain_cnt_q != 2'd2) begin
            drain_cnt_d = drain_cnt_q + 2'd1;
          end else if (bus.drained) begin
            tile_idx_d  = tile_next_s[TILE_W-1:0];
            exp_row_d   = '0;
            drain_cnt_d = 2'd0;
            if (tile_next_s < {1'b0, ntiles_q}) begin
              row_d   = reload_q ? ROW_LAST : '0;
              state_d = reload_q ? S_LOAD_W : S_STREAM;
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= S_IDLE;
      reload_q      <= 1'b0;
      gap_cfg_q     <= '0;
      ntiles_q      <= '0;
      tile_idx_q    <= '0;
      err_q         <= 1'b0;
      row_q         <= '0;
      gap_cnt_q     <= '0;
      drain_cnt_q   <= 2'd0;
      exp_row_q     <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      weight_en_q   <= 1'b0;
      input_en_q    <= 1'b0;
      partial_en_q  <= 1'b0;
      row_in_q      <= '0;
      row_ps_q      <= '0;
      arr_in_q      <= '0;
      arr_ps_q      <= '0;
`ifdef SYSARR_SEQ_PERF_EN
      perf_stall_q  <= 32'd0;
      perf_cycles_q <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      reload_q      <= reload_d;
      gap_cfg_q     <= gap_cfg_d;
      ntiles_q      <= ntiles_d;
      tile_idx_q    <= tile_idx_d;
      err_q         <= err_d;
      row_q         <= row_d;
      gap_cnt_q     <= gap_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      exp_row_q     <= exp_row_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      weight_en_q   <= weight_en_d;
      input_en_q    <= input_en_d;
      partial_en_q  <= partial_en_d;
      row_in_q      <= row_in_d;
      row_ps_q      <= row_ps_d;
      arr_in_q      <= arr_in_d;
      arr_ps_q      <= arr_ps_d;
`ifdef SYSARR_SEQ_PERF_EN
      perf_stall_q  <= perf_stall_d;
      perf_cycles_q <= perf_cycles_d;
`endif
    end
  end

endmodule

// File: tb/tb_sysarr_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sysarr_tile_sequencer
// Directed bench for sysarr_tile_sequencer (N=4, DW=16). The expected
// array-side traffic of each run is queued up front as an ordered list of row
// transfers (weights N-1..0, then inputs 0..N-1, with data drawn from the
// source counters); every cycle the observed bus is matched against that list
// or required to be all-zero. Cycle positions, done, busy, tile_idx and
// err_row_order are pinned with hand-computed offsets from the start pulse.
// -----------------------------------------------------------------------------
module tb_sysarr_tile_sequencer;

  logic       clk;
  logic       nRST;
  logic       start;
  logic       abort;
  logic       reload_each;
  logic [2:0] gap;
  logic [7:0] num_tiles;
  logic       busy;
  logic       done;
  logic [7:0] tile_idx;
  logic       err_row_order;
`ifdef SYSARR_SEQ_PERF_EN
  logic [31:0] perf_stall;
  logic [31:0] perf_cycles;
`endif

  sysarr_tile_sequencer_if #(.N(4), .DW(16)) ifc ();

  sysarr_tile_sequencer #(.N(4), .DW(16), .GAP_W(3), .TILE_W(8)) dut (
    .clk           (clk),
    .nRST          (nRST),
    .start         (start),
    .abort         (abort),
    .reload_each   (reload_each),
    .gap           (gap),
    .num_tiles     (num_tiles),
    .bus           (ifc),
    .busy          (busy),
    .done          (done),
    .tile_idx      (tile_idx),
    .err_row_order (err_row_order)
`ifdef SYSARR_SEQ_PERF_EN
    ,
    .perf_stall    (perf_stall),
    .perf_cycles   (perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_in;
    logic [1:0]  row;
    logic [63:0] d;
    logic [63:0] p;
  } beat_t;

  beat_t      q[$];
  int         total = 0;
  int         bad   = 0;
  int         wcnt  = 0;
  int         icnt  = 0;
  int         mw    = 0;
  int         mi    = 0;
  int         we_t[$];
  int         ie_t[$];
  int         dn_t[$];
  bit         busy_h[$];
  bit         err_h[$];
  int         tidx_h[$];
  int         oe_k[$];
  logic [1:0] oe_r[$];
  int         want[];

  function automatic logic [63:0] wd(input int j);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = 16'hA000 + 16'(j * 16 + l);
    return r;
  endfunction

  function automatic logic [63:0] id(input int j);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = 16'hB000 + 16'(j * 16 + l);
    return r;
  endfunction

  function automatic logic [63:0] pd(input int j);
    logic [63:0] r;
    for (int l = 0; l < 4; l++) r[l*16 +: 16] = 16'hC000 + 16'(j * 16 + l);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_list(input string nm, input int got[$], input int w[]);
    chk({nm, "_count"}, 64'(got.size()), 64'(w.size()));
    for (int i = 0; i < w.size() && i < got.size(); i++) chk(nm, 64'(got[i]), 64'(w[i]));
  endtask

  // Model: one tile's weight rows (highest row first) or input rows.
  task automatic push_w(input int nrows);
    for (int r = 3; r > 3 - nrows; r--) begin
      q.push_back('{1'b0, 2'(r), wd(mw), 64'd0});
      mw++;
    end
  endtask

  task automatic push_i();
    for (int r = 0; r < 4; r++) begin
      q.push_back('{1'b1, 2'(r), id(mi), pd(mi)});
      mi++;
    end
  endtask

  task automatic compare();
    beat_t e;
    if (ifc.weight_en || ifc.input_en || ifc.partial_en) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", {61'd0, ifc.weight_en, ifc.input_en, ifc.partial_en}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("beat_kind", {61'd0, ifc.weight_en, ifc.input_en, ifc.partial_en},
            e.is_in ? 64'd3 : 64'd4);
        chk("beat_row", 64'(ifc.row_in_en), 64'(e.row));
        chk("beat_data", ifc.array_in, e.d);
        if (e.is_in) begin
          chk("beat_ps_row", 64'(ifc.row_ps_en), 64'(e.row));
          chk("beat_ps_data", ifc.array_in_partials, e.p);
        end
      end
    end else begin
      chk("idle_rows", {60'd0, ifc.row_in_en, ifc.row_ps_en}, 64'd0);
      chk("idle_data", ifc.array_in, 64'd0);
      chk("idle_ps", ifc.array_in_partials, 64'd0);
    end
  endtask

  // One clock: check/record at the falling edge, advance sources after the rise.
  task automatic tick(input int k);
    bit hw;
    bit hi;
    @(negedge clk);
    compare();
    if (ifc.weight_en) we_t.push_back(k);
    if (ifc.input_en) ie_t.push_back(k);
    if (done) dn_t.push_back(k);
    busy_h.push_back(busy);
    err_h.push_back(err_row_order);
    tidx_h.push_back(int'(tile_idx));
    hw = ifc.w_valid && ifc.w_ready;
    hi = ifc.in_valid && ifc.in_ready;
    @(posedge clk);
    #1;
    if (hw) wcnt++;
    if (hi) icnt++;
    ifc.w_data  = wd(wcnt);
    ifc.in_data = id(icnt);
    ifc.ps_data = pd(icnt);
  endtask

  // ab: abort cycle, st/sl: in_valid stall window, rs: extra start while busy.
  task automatic run(input int ncyc, input logic [7:0] nt, input logic rel,
                     input logic [2:0] g, input int ab, input int st,
                     input int sl, input int rs);
    we_t.delete(); ie_t.delete(); dn_t.delete();
    busy_h.delete(); err_h.delete(); tidx_h.delete();
    for (int k = 0; k < ncyc; k++) begin
      start        = (k == 0) || (k == rs);
      num_tiles    = (k == rs) ? 8'd5 : nt;
      reload_each  = (k == rs) ? ~rel : rel;
      gap          = (k == rs) ? 3'd0 : g;
      abort        = (k == ab);
      ifc.w_valid  = (k != ab);
      ifc.in_valid = !(k >= st && k < st + sl);
      ifc.out_en   = 1'b0;
      ifc.row_out  = 2'd0;
      for (int i = 0; i < oe_k.size(); i++) begin
        if (oe_k[i] == k) begin
          ifc.out_en  = 1'b1;
          ifc.row_out = oe_r[i];
        end
      end
      tick(k);
    end
    start      = 1'b0;
    abort      = 1'b0;
    ifc.out_en = 1'b0;
    oe_k.delete();
    oe_r.delete();
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; abort = 1'b0; reload_each = 1'b0;
    gap = 3'd0; num_tiles = 8'd0;
    ifc.w_valid = 1'b0; ifc.in_valid = 1'b0; ifc.drained = 1'b1;
    ifc.out_en = 1'b0; ifc.row_out = 2'd0;
    ifc.w_data = wd(0); ifc.in_data = id(0); ifc.ps_data = pd(0);
    for (int i = 0; i < 3; i++) tick(0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tile_idx", 64'(tile_idx), 64'd0);
    chk("rst_err", 64'(err_row_order), 64'd0);
    chk("rst_ready", {62'd0, ifc.w_ready, ifc.in_ready}, 64'd0);
    nRST = 1'b1;
    tick(0); tick(0);

    // T1: one tile, reload, gap=1; stray start at k=8 must be ignored.
    push_w(4); push_i();
    run(24, 8'd1, 1'b1, 3'd1, -1, -1, 0, 8);
    want = '{2, 3, 4, 5};     chk_list("t1_weight_cycles", we_t, want);
    want = '{7, 9, 11, 13};   chk_list("t1_input_cycles", ie_t, want);
    want = '{16};             chk_list("t1_done_cycle", dn_t, want);
    chk("t1_busy_k0", 64'(busy_h[0]), 64'd0);
    chk("t1_busy_k1", 64'(busy_h[1]), 64'd1);
    chk("t1_tile_idx", 64'(tidx_h[17]), 64'd1);
    chk("t1_idle_after", 64'(busy_h[17]), 64'd0);

    // T2: two tiles, weights once, gap=0; order counter restarts per tile.
    push_w(4); push_i(); push_i();
    oe_k = '{6, 7, 14, 15, 16, 17};
    oe_r = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    run(26, 8'd2, 1'b0, 3'd0, -1, -1, 0, -1);
    want = '{2, 3, 4, 5};                     chk_list("t2_weight_cycles", we_t, want);
    want = '{7, 8, 9, 10, 14, 15, 16, 17};    chk_list("t2_input_cycles", ie_t, want);
    want = '{20};                             chk_list("t2_done_cycle", dn_t, want);
    chk("t2_tile_idx_mid", 64'(tidx_h[13]), 64'd1);
    chk("t2_tile_idx_done", 64'(tidx_h[20]), 64'd2);
    chk("t2_err", 64'(err_h[25]), 64'd0);

    // T3: in_valid low for 3 cycles mid-stream; output rows 0,2,1,3.
    push_w(4); push_i();
    oe_k = '{2, 3, 4, 5};
    oe_r = '{2'd0, 2'd2, 2'd1, 2'd3};
    run(22, 8'd1, 1'b1, 3'd0, -1, 8, 3, -1);
    want = '{7, 8, 12, 13};   chk_list("t3_input_cycles", ie_t, want);
    want = '{16};             chk_list("t3_done_cycle", dn_t, want);
    chk("t3_err_before", 64'(err_h[3]), 64'd0);
    chk("t3_err_set", 64'(err_h[4]), 64'd1);
    chk("t3_err_sticky", 64'(err_h[21]), 64'd1);
`ifdef SYSARR_SEQ_PERF_EN
    chk("t3_perf_stall", 64'(perf_stall), 64'd3);
    chk("t3_perf_cycles", 64'(perf_cycles), 64'd16);
`endif

    // T5: abort in LOAD_W after two rows; error set in this run is retained.
    push_w(2);
    oe_k = '{1};
    oe_r = '{2'd1};
    run(8, 8'd1, 1'b1, 3'd0, 3, -1, 0, -1);
    want = '{2, 3};           chk_list("t5_weight_cycles", we_t, want);
    chk("t5_no_done", 64'(dn_t.size()), 64'd0);
    chk("t5_busy_after_abort", 64'(busy_h[4]), 64'd0);
    chk("t5_err_until_start", 64'(err_h[0]), 64'd1);
    chk("t5_err_cleared", 64'(err_h[1]), 64'd0);
    chk("t5_err_retained", 64'(err_h[7]), 64'd1);
    chk("t5_tile_idx", 64'(tidx_h[7]), 64'd0);

    // T6: clean run after abort, gap=2.
    push_w(4); push_i();
    run(30, 8'd1, 1'b1, 3'd2, -1, -1, 0, -1);
    want = '{2, 3, 4, 5};     chk_list("t6_weight_cycles", we_t, want);
    want = '{7, 10, 13, 16};  chk_list("t6_input_cycles", ie_t, want);
    want = '{19};             chk_list("t6_done_cycle", dn_t, want);
    chk("t6_err_clear", 64'(err_h[29]), 64'd0);
    chk("t6_tile_idx", 64'(tidx_h[29]), 64'd1);

    // T7: num_tiles=0 goes straight to DONE.
    run(5, 8'd0, 1'b1, 3'd0, -1, -1, 0, -1);
    want = '{1};              chk_list("t7_done_cycle", dn_t, want);
    chk("t7_no_beats", 64'(we_t.size() + ie_t.size()), 64'd0);
    chk("t7_busy_done", 64'(busy_h[1]), 64'd1);
    chk("t7_busy_idle", 64'(busy_h[2]), 64'd0);
    chk("t7_tile_idx", 64'(tidx_h[2]), 64'd0);

    // T8: abort and start together in IDLE; start is dropped.
    run(4, 8'd1, 1'b1, 3'd0, 0, -1, 0, -1);
    chk("t8_busy", 64'(busy_h[1]), 64'd0);
    chk("t8_no_done", 64'(dn_t.size()), 64'd0);
    chk("t8_no_beats", 64'(we_t.size()), 64'd0);

    chk("model_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysarr_tile_sequencer.md
Name: sysarr_tile_sequencer

Overview:
Hardware row sequencer that feeds the systolic_array memory-side port. It loads weight rows, then streams input/partial rows for NUM_TILES back-to-back tiles with a programmable inter-row gap. It then waits for drain and checks that output rows return in order. It sits between the scratchpad/DMA row sources and systolic_array, generalising the load-weights / stream-rows / wait-drained flow to multi-tile, variable-spacing operation.

Parameters:
N, 4, array dimension (rows per matrix)
DW, 16, element width (fp16)
GAP_W, 3, width of the inter-row gap field
TILE_W, 8, width of the tile count

Ports:
clk  in  1  clock
nRST  in  1  async active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
abort  in  1  return to IDLE from any state
reload_each  in  1  1: load weights before every tile; 0: first tile only
gap  in  GAP_W  idle cycles inserted after each input row (0 = streaming)
num_tiles  in  TILE_W  tiles to run; 0 = none
w_valid  in  1  weight row available
w_ready  out  1  weight row accepted this cycle
w_data  in  N*DW  weight row
in_valid  in  1  input+partial row available
in_ready  out  1  input row accepted this cycle
in_data  in  N*DW  input row
ps_data  in  N*DW  partial-sum row
weight_en  out  1  to array
input_en  out  1  to array
partial_en  out  1  to array
row_in_en  out  $clog2(N)  input/weight row index
row_ps_en  out  $clog2(N)  partial row index
array_in  out  N*DW  row data
array_in_partials  out  N*DW  partial data
drained  in  1  array has no in-flight work
out_en  in  1  array output row valid
row_out  in  $clog2(N)  array output row index
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last tile drained
tile_idx  out  TILE_W  current tile number
err_row_order  out  1  sticky out-of-order output flag

Behaviour:
- Reset: state IDLE. All outputs 0, including the array-side buses, enables, done, err_row_order and tile_idx.
- start in IDLE latches reload_each, gap and num_tiles; clears tile_idx and err_row_order. start outside IDLE is ignored.
- num_tiles==0: go directly to DONE; done pulses 1 cycle after start.
- States: IDLE, LOAD_W, BUBBLE, STREAM, GAP, DRAIN, DONE.
- LOAD_W:
  - w_ready=1.
  - Each w_valid&&w_ready beat issues one row: index N-1 first, down to 0.
  - w_valid low stalls; no enable is issued.
  - After row 0, go to BUBBLE for exactly 1 cycle, then STREAM. The bubble is mandatory weight-to-input spacing.
- STREAM:
  - in_ready=1.
  - Each accepted beat issues input and partial row k (k = 0 to N-1) with input_en=partial_en=1 and row_in_en=row_ps_en=k.
  - After a beat: if gap>0, go to GAP for exactly gap cycles (in_ready=0), then return to STREAM.
  - After row N-1, go to DRAIN (no gap).
- Array-side outputs are registered. A beat accepted in cycle t drives the enables and data in cycle t+1 only. All other cycles drive enables 0 and data 0.
- DRAIN:
  - drained is ignored for the first 2 cycles, which masks stale drained.
  - Thereafter drained==1 completes the tile and increments tile_idx.
  - If tile_idx+1 < num_tiles: go to LOAD_W if reload_each, else STREAM.
  - Otherwise go to DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- Output order check:
  - An expected-row counter resets to 0 per tile and increments on each out_en, wrapping from N-1 to 0.
  - out_en with row_out != expected sets err_row_order (sticky until next start).
  - The counter still advances on a mismatch.
- abort (highest priority, any state): next cycle state=IDLE, all enables 0, no done pulse. Latched config, tile_idx and err_row_order are retained.
- If abort and start are high in the same cycle in IDLE, abort wins and start is dropped.
- w_ready and in_ready are combinational from state only, with no dependence on valid.

Optional Feature:
SYSARR_SEQ_PERF_EN:
- When defined, adds two outputs, both cleared on start:
  - perf_stall  out 32: counts cycles spent in LOAD_W or STREAM with valid low.
  - perf_cycles out 32: counts busy cycles.
- When undefined, neither port nor counter exists.

Test Plan:
- N=4, num_tiles=1, reload_each=1, gap=1, valid always high:
  - weight_en on 4 consecutive cycles with rows 3,2,1,0.
  - 1 bubble cycle.
  - input_en on rows 0,1,2,3, each separated by one idle cycle.
  - done pulses 3+ cycles after drained rises.
- num_tiles=2, reload_each=0, gap=0: weights loaded once; tile 2 has 4 input rows on consecutive cycles with no weight_en; tile_idx reaches 2 before done.
- in_valid dropped for 3 cycles mid-STREAM: no input_en during the stall; row indices stay contiguous; perf_stall=3 (perf build).
- out_en row_out sequence 0,2,1,3: err_row_order sets on the cycle after row 2 and stays set until the next start.
- abort during LOAD_W after 2 rows: enables 0 the next cycle, busy=0, done never pulses; a following start runs cleanly.
- num_tiles=0 start: no enables; done pulses 1 cycle after start.
